// File: rtl/lap_stopwatch_pkg.sv
// Shared types and elaboration helpers for the lap stopwatch.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } sw_state_t;

    // Index width for a table of 'depth' entries (at least one bit).
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Clock cycles per count tick.
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/lap_stopwatch_if.sv
// Command/status bundle between the button front end, the stopwatch and the display path.
interface lap_stopwatch_if #(
    parameter int COUNT_W = 13
);
    logic               start;
    logic               stop;
    logic               split;
    logic               lap;
    logic               clear;
    logic               mode_down;
    logic [COUNT_W-1:0] preset;
    logic               load;
    logic               lap_rd;
    logic [COUNT_W-1:0] displayed_time;
    logic               running;
    logic               split_active;
    logic [COUNT_W-1:0] lap_data;
    logic               lap_valid;
    logic               lap_full;
    logic               lap_ovf;
    logic               overflow;
    logic               alarm;
    logic               tick_led;

    modport master (
        output start, stop, split, lap, clear, mode_down, preset, load, lap_rd,
        input  displayed_time, running, split_active, lap_data, lap_valid,
               lap_full, lap_ovf, overflow, alarm, tick_led
    );

    modport slave (
        input  start, stop, split, lap, clear, mode_down, preset, load, lap_rd,
        output displayed_time, running, split_active, lap_data, lap_valid,
               lap_full, lap_ovf, overflow, alarm, tick_led
    );
endinterface

// File: rtl/lap_stopwatch_fifo.sv
// Show-ahead lap-time FIFO; pointers carry one extra bit to tell full from empty.
module lap_fifo
    import stopwatch_pkg::*;
#(
    parameter int WIDTH = 13,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic             ovf
);
    localparam int AW = ptr_w(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             r_ovf;
    logic             w_do_rd;
    logic             w_do_wr;

    assign empty   = (r_wptr == r_rptr);
    assign full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_rd = rd && !empty;
    // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
    assign w_do_wr = wr && (!full || w_do_rd);
    assign rdata   = empty ? '0 : r_mem[r_rptr[AW-1:0]];
    assign ovf     = r_ovf;

    // Pointer and sticky-overflow bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
        end else if (clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_do_wr) r_wptr <= r_wptr + PTR_ONE;
            if (w_do_rd) r_rptr <= r_rptr + PTR_ONE;
            if (wr && !w_do_wr) r_ovf <= 1'b1;
        end
    end

    // Storage array; contents are meaningless while the pointers say empty.
    always_ff @(posedge clk) begin
        if (w_do_wr && !clr) r_mem[r_wptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/lap_stopwatch.sv
// Stopwatch core: run/pause/countdown FSM, tick prescaler, time counter, split freeze, lap FIFO.
module lap_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 10,
    parameter int COUNT_W   = 13,
    parameter int LAP_DEPTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    lap_stopwatch_if.slave sw
);
    localparam int                 DIV        = calc_div(CLK_HZ, TICK_HZ);
    localparam int                 PRESC_W    = ptr_w(DIV);
    localparam logic [PRESC_W-1:0] PRESC_MAX  = PRESC_W'(DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
    localparam logic [COUNT_W-1:0] CNT_MAX    = '1;
    localparam logic [COUNT_W-1:0] CNT_ONE    = COUNT_W'(1);

    sw_state_t          r_state;
    logic               r_dir;
    logic [PRESC_W-1:0] r_presc;
    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] r_split_count;
    logic               r_split_active;
    logic               r_overflow;
    logic               r_alarm;
    logic               r_tick_led;
    logic               w_tick;
    logic               w_start_dir;
    logic               w_start_done;
    logic               w_hit_zero;
    logic               w_lap_wr;
    logic               w_fifo_empty;

    assign w_tick       = (r_state == RUN) && (r_presc == PRESC_MAX);
    // Direction is only latched on leaving IDLE; afterwards the latched value governs.
    assign w_start_dir  = (r_state == IDLE) ? sw.mode_down : r_dir;
    assign w_start_done = w_start_dir && (r_count == '0);
    assign w_hit_zero   = w_tick && r_dir && (r_count == CNT_ONE);
    assign w_lap_wr     = sw.lap && (r_state != IDLE);

    // Control FSM with prescaler, counter and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_dir      <= 1'b0;
            r_presc    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_alarm    <= 1'b0;
            r_tick_led <= 1'b0;
        end else if (sw.clear) begin
            r_state    <= IDLE;
            r_dir      <= 1'b0;
            r_presc    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_alarm    <= 1'b0;
            r_tick_led <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_presc <= '0;
                    if (sw.load) begin
                        r_count <= sw.preset;
                    end else if (sw.start && !sw.stop) begin
                        r_dir <= sw.mode_down;
                        if (w_start_done) begin
                            r_state <= DONE;
                            r_alarm <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (w_tick) begin
                        r_presc    <= '0;
                        r_tick_led <= ~r_tick_led;
                        if (r_dir) begin
                            r_count <= r_count - CNT_ONE;
                        end else begin
                            r_count <= r_count + CNT_ONE;
                            if (r_count == CNT_MAX) r_overflow <= 1'b1;
                        end
                    end else begin
                        r_presc <= r_presc + PRESC_ONE;
                    end
                    // Reaching zero outranks a simultaneous stop so the alarm is never missed.
                    if (w_hit_zero) begin
                        r_state <= DONE;
                        r_alarm <= 1'b1;
                    end else if (sw.stop) begin
                        r_state <= PAUSED;
                    end
                end
                PAUSED: begin
                    if (sw.load) begin
                        r_count <= sw.preset;
                        r_presc <= '0;
                    end else if (sw.start && !sw.stop) begin
                        if (w_start_done) begin
                            r_state <= DONE;
                            r_alarm <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                DONE: begin
                    if (sw.load) begin
                        r_count <= sw.preset;
                        r_presc <= '0;
                        r_alarm <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Split freeze: each pulse captures the live count and toggles the freeze.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_split_count  <= '0;
            r_split_active <= 1'b0;
        end else if (sw.clear) begin
            r_split_count  <= '0;
            r_split_active <= 1'b0;
        end else if (sw.split) begin
            r_split_count  <= r_count;
            r_split_active <= ~r_split_active;
        end
    end

    lap_fifo #(
        .WIDTH (COUNT_W),
        .DEPTH (LAP_DEPTH)
    ) u_lap_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (sw.clear),
        .wr    (w_lap_wr),
        .wdata (r_count),
        .rd    (sw.lap_rd),
        .rdata (sw.lap_data),
        .empty (w_fifo_empty),
        .full  (sw.lap_full),
        .ovf   (sw.lap_ovf)
    );

    assign sw.displayed_time = r_split_active ? r_split_count : r_count;
    assign sw.running        = (r_state == RUN);
    assign sw.split_active   = r_split_active;
    assign sw.lap_valid      = ~w_fifo_empty;
    assign sw.overflow       = r_overflow;
    assign sw.alarm          = r_alarm;
    assign sw.tick_led       = r_tick_led;
endmodule

// File: doc/lap_stopwatch.md
Name: lap_stopwatch

Overview:
- Parametrised successor to the team's single-channel stopwatch: tick prescaler, up/down time counter, split-freeze display, lap-time FIFO.
- Runs entirely in the `clk` domain. The tick is a one-cycle enable, not a derived clock.
- Sits between the debounced button/pulse front end and the display/BCD formatter. The `tick_led` output drives a board LED.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency.
- TICK_HZ, 10, count resolution in Hz. DIV = CLK_HZ/TICK_HZ, must be ≥ 2.
- COUNT_W, 13, width of time counter, split register and lap entries.
- LAP_DEPTH, 8, lap FIFO entries, power of two, ≥ 2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  single-cycle pulse: begin/resume counting
- stop  in  1  single-cycle pulse: pause counting
- split  in  1  single-cycle pulse: toggle split-freeze display
- lap  in  1  single-cycle pulse: push current count into lap FIFO
- clear  in  1  synchronous clear of count, split, FIFO, flags
- mode_down  in  1  1 = countdown, 0 = count up; sampled only in IDLE
- preset  in  COUNT_W  countdown start value
- load  in  1  pulse: count <= preset; accepted in IDLE/PAUSED/DONE only
- lap_rd  in  1  pop FIFO head
- displayed_time  out  COUNT_W  split_count if split_active, else count
- running  out  1  state == RUN
- split_active  out  1  split-freeze flag
- lap_data  out  COUNT_W  FIFO head (show-ahead), 0 when empty
- lap_valid  out  1  FIFO not empty
- lap_full  out  1  FIFO full
- lap_ovf  out  1  sticky: lap push dropped while full
- overflow  out  1  sticky: up-count wrapped
- alarm  out  1  countdown reached 0 (level, held in DONE)
- tick_led  out  1  toggles on every tick

Behaviour:
- Reset (async) and `clear` (sync) both set:
  - state = IDLE
  - count, split_count, prescaler = 0
  - split_active, lap_ovf, overflow, alarm, tick_led = 0
  - FIFO empty
- All outputs are registered or derived directly from registers.
- Command priority within a cycle: clear > load > stop > start. Start and stop in the same cycle: stop wins.
- Prescaler:
  - Counts 0..DIV-1 only in RUN.
  - `tick` is asserted in the cycle where prescaler == DIV-1, then the prescaler wraps to 0.
  - Holds its value in PAUSED, so partial intervals are preserved.
  - Reset to 0 by clear, load, and entry to IDLE.
- States:
  - IDLE: start -> RUN. `mode_down` is latched into `dir` on this transition.
  - RUN: stop -> PAUSED. Down mode with tick while count == 1 -> DONE.
  - PAUSED: start -> RUN; load stays PAUSED.
  - DONE: count = 0, alarm = 1. start is ignored; load -> IDLE with alarm cleared.
- Count update on tick in RUN:
  - Up: count + 1 modulo 2^COUNT_W. On wrap 2^COUNT_W-1 -> 0, set `overflow`.
  - Down: count - 1.
  - start in down mode with count == 0 -> DONE immediately; alarm rises the next cycle.
- Split: each split pulse sets split_count <= count and toggles split_active. Counting continues underneath.
- Lap:
  - A lap pulse writes the current count (pre-tick value in the same cycle) into the FIFO.
  - Accepted in any state except IDLE.
  - Full and no pop: drop the write and set `lap_ovf`.
  - Full with simultaneous pop: both occur; occupancy unchanged.
  - lap_rd on empty is ignored.
  - lap_data updates the cycle after a pop or after a write to an empty FIFO.
- Reset asserted mid-RUN: everything clears immediately; counting resumes only after a new start.

Decomposition:
- Package `stopwatch_pkg`:
  - state enum: IDLE, RUN, PAUSED, DONE
  - `clog2`-based pointer width function
  - DIV localparam computation helper
- Sub-module `lap_fifo`, parameters WIDTH and DEPTH. Ports: clk, reset, clr, wr, wdata, rd, rdata, empty, full, ovf. Show-ahead, one extra pointer bit for full/empty.
- The top level holds the FSM, prescaler, counter and split logic.

Test Plan:
- CLK_HZ=10, TICK_HZ=1 (DIV=10), up mode: start, wait 35 cycles -> displayed_time=3, tick_led toggled 3 times; stop, wait 20 cycles, start, wait 5 -> displayed_time=4 (partial interval preserved).
- COUNT_W=4, up mode: run 16 ticks -> count wraps to 0, overflow=1, stays 1 until clear.
- Down mode: preset=3, load, start -> 3,2,1,0 at ticks; alarm=1 and state DONE after the 3rd tick; start ignored; load -> alarm=0, IDLE.
- Split at count=5 -> displayed_time stays 5 while count reaches 8; second split at count=8 -> displayed_time=8, split_active=0.
- LAP_DEPTH=2: laps at counts 2, 4, 6 -> lap_full=1, lap_ovf=1, lap_data=2; lap_rd -> lap_data=4; lap_rd -> lap_valid=0; third lap_rd ignored.
- Simultaneous start+stop in IDLE -> stays IDLE. Assert reset during RUN at count=7 -> displayed_time=0, FIFO empty, running=0 on the same edge.
